// File: rtl/addsub_pkg.sv
// Shared constants for the add/subtract arbiter: default width, output FSM
// encoding and requester identifiers.
package addsub_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // Two's-complement overflow from the carries around the sign bit.
    function automatic logic ovf_flag(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage

// File: rtl/addsub_unit.sv
// Combinational ripple-carry adder/subtractor: sum = a + (b ^ {W{sub}}) + sub.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module addsub_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    always_comb begin
        logic v_c;
        logic v_b;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        v_c     = i_sub;
        v_b     = 1'b0;
        o_sum   = '0;
        o_c_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            v_b      = i_b[i] ^ i_sub;
            o_sum[i] = i_a[i] ^ v_b ^ v_c;
            if (i == WIDTH - 1) begin
                o_c_msb = v_c;
            end
            v_c = (i_a[i] & v_b) | (v_c & (i_a[i] ^ v_b));
        end
        o_cout = v_c;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one adder/subtractor under round-robin arbitration;
// a single result register with a valid/ready handshake holds each answer.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             m0,
    input  logic             m1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_id
);

    logic [0:0]       r_state;
    logic             r_last;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_id;

    logic             w_full;
    logic             w_accept_ok;
    logic             w_win0;
    logic             w_win1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any_gnt;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_m;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;

    assign w_full      = (r_state == ST_FULL);
    assign w_accept_ok = (r_state == ST_EMPTY) || (w_full && res_ready);

    // On contention the requester that was not granted last time wins.
    assign w_win0 = req0 && (!req1 || (r_last == ID_REQ1));
    assign w_win1 = req1 && (!req0 || (r_last == ID_REQ0));

    assign w_gnt0    = !rst && w_accept_ok && w_win0;
    assign w_gnt1    = !rst && w_accept_ok && w_win1;
    assign w_any_gnt = w_gnt0 || w_gnt1;

    assign w_a = w_gnt1 ? a1 : a0;
    assign w_b = w_gnt1 ? b1 : b0;
    assign w_m = w_gnt1 ? m1 : m0;

    addsub_unit #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a     (w_a),
        .i_b     (w_b),
        .i_sub   (w_m),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_last  <= ID_REQ1;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_id    <= ID_REQ0;
        end else if (w_any_gnt) begin
            r_state <= ST_FULL;
            r_last  <= w_gnt1 ? ID_REQ1 : ID_REQ0;
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_ovf   <= ovf_flag(w_c_msb, w_cout);
            r_id    <= w_gnt1 ? ID_REQ1 : ID_REQ0;
        end else if (w_full && res_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign res_valid = w_full;
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;
    assign res_ovf   = r_ovf;
    assign res_id    = r_id;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for contention, backpressure and reset.
module tb_addsub_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, m0, m1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic       res_valid, res_ready;
    logic [3:0] res_sum;
    logic       res_cout, res_ovf, res_id;

    int n_tests = 0;
    int n_fail  = 0;

    addsub_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .m0        (m0),
        .m1        (m1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req0, req1, m0, m1;
        logic [3:0] a0, b0, a1, b1;
        logic       ready;
        logic       e_gnt0, e_gnt1, e_valid;
        logic [3:0] e_sum;
        logic       e_cout, e_ovf, e_id;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_result(input string tag, input logic v, input logic [3:0] s,
                                input logic c, input logic o, input logic id);
        check({tag, ".valid"}, {31'd0, res_valid}, {31'd0, v});
        check({tag, ".sum"},   {28'd0, res_sum},   {28'd0, s});
        check({tag, ".cout"},  {31'd0, res_cout},  {31'd0, c});
        check({tag, ".ovf"},   {31'd0, res_ovf},   {31'd0, o});
        check({tag, ".id"},    {31'd0, res_id},    {31'd0, id});
    endtask

    task automatic check_gnt(input string tag, input logic g0, input logic g1);
        check({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, g0});
        check({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, g1});
    endtask

    initial begin
        // req0 req1 m0 m1 a0 b0 a1 b1 ready | gnt0 gnt1 valid sum cout ovf id
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd5, 4'd0, 4'd0, 1'b1,
                     1'b1, 1'b0, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd5, 4'd3, 1'b1,
                     1'b0, 1'b1, 1'b1, 4'd2,  1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 4'd5, 1'b1,
                     1'b0, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1,
                     1'b0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8, 4'd0, 4'd0, 1'b1,
                     1'b1, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1,
                     1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd1, 1'b1,
                     1'b0, 1'b1, 1'b1, 4'd7,  1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd1, 4'd2, 4'd2, 1'b1,
                     1'b1, 1'b0, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd1, 4'd2, 4'd2, 1'b1,
                     1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd1, 4'd2, 4'd2, 1'b1,
                     1'b1, 1'b0, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0, 4'd0, 1'b0,
                     1'b0, 1'b0, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0};

        rst = 1'b1; req0 = 1'b1; req1 = 1'b0; m0 = 1'b0; m1 = 1'b0;
        a0 = 4'd3; b0 = 4'd5; a1 = 4'd0; b1 = 4'd0; res_ready = 1'b1;

        // Reset state, with a request pending that must not be granted
        @(posedge clk); @(posedge clk); #1;
        check_gnt("reset", 1'b0, 1'b0);
        check_result("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            req0 = vecs[i].req0; req1 = vecs[i].req1;
            m0 = vecs[i].m0; m1 = vecs[i].m1;
            a0 = vecs[i].a0; b0 = vecs[i].b0; a1 = vecs[i].a1; b1 = vecs[i].b1;
            res_ready = vecs[i].ready;
            #1;
            check_gnt($sformatf("vec%0d", i), vecs[i].e_gnt0, vecs[i].e_gnt1);
            @(posedge clk); #1;
            check_result($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_sum,
                         vecs[i].e_cout, vecs[i].e_ovf, vecs[i].e_id);
            @(negedge clk);
        end

        // Contention straight after reset: 0,1,0,1,... one result per cycle
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; res_ready = 1'b1;
        m0 = 1'b0; a0 = 4'd1; b0 = 4'd1; m1 = 1'b0; a1 = 4'd2; b1 = 4'd3;
        #1;
        check_gnt("rst_hold", 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_gnt($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
            @(posedge clk); #1;
            check_result($sformatf("rr%0d", k), 1'b1, ((k % 2) == 0) ? 4'd2 : 4'd5,
                         1'b0, 1'b0, (k % 2) == 1);
            @(negedge clk);
        end

        // Backpressure: FULL holding id1 sum5, consumer stalls for 3 cycles
        req1 = 1'b0; req0 = 1'b1; m0 = 1'b0; a0 = 4'd4; b0 = 4'd4; res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_gnt($sformatf("bp%0d", k), 1'b0, 1'b0);
            @(posedge clk); #1;
            check_result($sformatf("bp%0d", k), 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        check_gnt("bp_release", 1'b1, 1'b0);
        @(posedge clk); #1;
        check_result("bp_release", 1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // Reset while FULL with req1 pending; last grant was 0, so without
        // reset requester 1 would win the next contention
        req0 = 1'b0; req1 = 1'b1; m1 = 1'b1; a1 = 4'd9; b1 = 4'd2;
        res_ready = 1'b0; rst = 1'b1;
        #1;
        check_gnt("rst_mid", 1'b0, 1'b0);
        @(posedge clk); #1;
        check_result("rst_mid", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; res_ready = 1'b1;
        m0 = 1'b0; a0 = 4'd6; b0 = 4'd5;
        #1;
        check_gnt("post_rst", 1'b1, 1'b0);
        @(posedge clk); #1;
        check_result("post_rst", 1'b1, 4'd11, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand and result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0 / req1  input  1  requester 0/1 has an operation pending.
REQ-005 SHALL have ports: m0 / m1  input  1  requester mode: 0 = add A+B, 1 = subtract A-B.
REQ-006 SHALL have ports: a0, b0 / a1, b1  input  WIDTH  requester operands.
REQ-007 SHALL have ports: gnt0 / gnt1  output  1  combinational accept strobe for requester 0/1.
REQ-008 SHALL have port: res_valid  output  1  result register holds an undelivered result.
REQ-009 SHALL have port: res_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have ports: res_sum  output  WIDTH; res_cout  output  1; res_ovf  output  1; res_id  output  1  (source requester).

Function
REQ-011 SHALL time-share one WIDTH-bit adder/subtractor: sum = A + (B xor {WIDTH{m}}) + m; cout = adder carry-out.
REQ-012 SHALL set res_ovf = carry into MSB xor carry out of MSB (two's-complement overflow).
REQ-013 SHALL use a two-state output FSM: EMPTY (res_valid=0), FULL (res_valid=1).
REQ-014 SHALL define accept_ok = (state==EMPTY) or (res_valid and res_ready).
REQ-015 SHALL assert at most one of gnt0/gnt1 per cycle; a gnt SHALL be asserted only while that req is high and accept_ok is true.
REQ-016 SHALL arbitrate round-robin: one requester pending -> grant it; both pending -> grant the requester not granted most recently.
REQ-017 SHALL update the last-grant pointer only on a cycle where a gnt is asserted.
REQ-018 SHALL, on grant, sample the granted operands and mode that cycle and present the result, cout, ovf, id registered on the next cycle (latency 1).
REQ-019 Transitions: EMPTY+grant -> FULL; EMPTY+no grant -> EMPTY; FULL+res_ready+grant -> FULL with new result; FULL+res_ready+no grant -> EMPTY; FULL+!res_ready -> FULL, outputs held stable.
REQ-020 SHALL require requesters to hold req, m, a, b stable until gnt; dropping req before gnt withdraws the request without side effect.
REQ-021 SHALL keep res_sum/res_cout/res_ovf/res_id unchanged whenever no grant occurs.
REQ-022 SHALL sustain one result per cycle when res_ready is held high and requests are continuous.

Reset
REQ-023 SHALL, while rst is high at a clock edge, force state=EMPTY, res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0, last-grant pointer=1 (requester 0 wins first contention).
REQ-024 SHALL hold gnt0=gnt1=0 while rst is high; a pending result SHALL be discarded by reset mid-operation.

Structure
REQ-025 SHALL place WIDTH default, FSM state encoding (EMPTY/FULL) and requester-id constants in the shared package addsub_pkg.
REQ-026 SHALL instantiate one combinational sub-module, addsub_unit (ripple-carry add/sub, exposes sum, cout, MSB carry-in), as the only adder in the block.

Verification
REQ-027 Add: req0=1, m0=0, a0=3, b0=5, res_ready=1 -> gnt0 same cycle; next cycle res_valid=1, res_sum=8, res_cout=0, res_ovf=1, res_id=0.
REQ-028 Subtract: req1=1, m1=1, a1=5, b1=3 -> res_sum=2, res_cout=1, res_ovf=0, res_id=1; then a1=3, b1=5 -> res_sum=14, res_cout=0, res_ovf=0.
REQ-029 Contention: req0=req1=1 continuously after reset, res_ready=1 -> grants alternate 0,1,0,1; res_valid high every cycle after the first.
REQ-030 Backpressure: result FULL, res_ready=0 for 3 cycles with req0=1 -> gnt0=0, outputs stable; res_ready=1 -> gnt0=1 same cycle, new result next cycle.
REQ-031 Reset mid-operation: rst=1 while FULL and req1=1 -> next cycle res_valid=0, gnt1=0; after release with req0=req1=1, gnt0 first.
